// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running DrawX/DrawY counters, active-video decode,
// sync outputs delayed to line up with registered RGB, and line/frame start markers.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int SYNC_DELAY = 1
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be in 0..4");
    end

    localparam logic [9:0]  X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] X_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] Y_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_line_start;
    logic        r_frame_start;
    logic [15:0] r_frame_count;
    logic [SYNC_DELAY:0] r_hs_pipe;
    logic [SYNC_DELAY:0] r_vs_pipe;

    logic [9:0]  w_next_x;
    logic [9:0]  w_next_y;
    logic        w_x_wrap;
    logic        w_frame_wrap;
    logic        w_hs_next;
    logic        w_vs_next;

    always_comb begin
        w_x_wrap     = (r_x == X_LAST);
        w_frame_wrap = w_x_wrap && (r_y == Y_LAST);
        w_next_x     = w_x_wrap ? 10'd0 : r_x + 10'd1;
        w_next_y     = r_y;
        if (w_x_wrap) begin
            w_next_y = (r_y == Y_LAST) ? 10'd0 : r_y + 10'd1;
        end
        w_hs_next = (({1'b0, w_next_x} >= HS_BEG) && ({1'b0, w_next_x} < HS_END)) ? HS_POL : ~HS_POL;
        w_vs_next = (({1'b0, w_next_y} >= VS_BEG) && ({1'b0, w_next_y} < VS_END)) ? VS_POL : ~VS_POL;
    end

    // Pipe stage 0 decodes the next count, so it is aligned with DrawX/DrawY;
    // each further stage adds one clock of delay.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x           <= X_LAST;
            r_y           <= Y_LAST;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= 16'hFFFF;
            r_hs_pipe     <= {(SYNC_DELAY + 1){~HS_POL}};
            r_vs_pipe     <= {(SYNC_DELAY + 1){~VS_POL}};
        end else begin
            r_x           <= w_next_x;
            r_y           <= w_next_y;
            r_line_start  <= (w_next_x == 10'd0);
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            r_hs_pipe[0] <= w_hs_next;
            r_vs_pipe[0] <= w_vs_next;
            for (int i = 1; i <= SYNC_DELAY; i++) begin
                r_hs_pipe[i] <= r_hs_pipe[i-1];
                r_vs_pipe[i] <= r_vs_pipe[i-1];
            end
        end
    end

    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign blank       = ({1'b0, r_x} < X_ACT_END) && ({1'b0, r_y} < Y_ACT_END);
    assign hs          = r_hs_pipe[SYNC_DELAY];
    assign vs          = r_vs_pipe[SYNC_DELAY];
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator on the pixel clock; the driving end of the DrawX/DrawY/blank scan interface that the sprite and palette display blocks consume.
- Produces the scan coordinates, the active-video flag, and the hs/vs sync pins.
- Sync outputs are delayed by a parameterised number of cycles to line up with the registered RGB the display blocks produce.
- Also provides line and frame start pulses and a frame counter for animation logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- HS_POL, 0, hs asserted level (0 = active-low)
- VS_POL, 0, vs asserted level (0 = active-low)
- SYNC_DELAY, 1, clocks of delay on hs/vs relative to DrawX/DrawY/blank (0..4)

Ports:
- vga_clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- blank  out  1  1 = visible pixel (display drives colour), 0 = blanking interval
- hs  out  1  horizontal sync, delayed SYNC_DELAY clocks
- vs  out  1  vertical sync, delayed SYNC_DELAY clocks
- line_start  out  1  one-clock pulse in the cycle DrawX==0
- frame_start  out  1  one-clock pulse in the cycle DrawX==0 && DrawY==0
- frame_count  out  16  frames started since reset; first frame after reset = 0

Behaviour:
- Clock and reset: one clock, vga_clk; reset is asynchronous and active-low on reset_n; all state is on posedge vga_clk.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525. Both must be ≤ 1024; violation is an elaboration error.
- Counters: DrawX and DrawY are the counter registers themselves, no extra latency.
  - Each clock, DrawX increments.
  - At DrawX==H_TOTAL-1 it wraps to 0 and DrawY increments.
  - DrawY wraps from V_TOTAL-1 to 0 on the same edge on which DrawX wraps.
- Reset values, applied immediately on reset_n low without a clock:
  - DrawX = H_TOTAL-1, DrawY = V_TOTAL-1, so the first edge after release lands on (0,0).
  - line_start = 0, frame_start = 0, frame_count = 16'hFFFF.
  - Every hs/vs delay stage is loaded with the inactive level, so hs = ~HS_POL and vs = ~VS_POL.
  - blank = 0.
- blank: combinational decode of the counter registers = (DrawX < H_ACTIVE) && (DrawY < V_ACTIVE).
- Raw sync:
  - hs_raw asserted when H_ACTIVE+H_FP ≤ DrawX < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw asserted when V_ACTIVE+V_FP ≤ DrawY < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole line.
  - Levels follow HS_POL/VS_POL.
- Sync delay:
  - hs/vs pass through a SYNC_DELAY-deep register shift chain.
  - With SYNC_DELAY=0 they are a registered decode of next-count, so the edges coincide exactly with DrawX/DrawY.
  - Outputs are glitch-free (register-driven) in all cases.
- Pulses:
  - line_start and frame_start are registered from the next-count decode, so each is high exactly during the cycle its condition holds.
  - frame_count increments on the same edge that asserts frame_start and wraps 16'hFFFF→0.
- Reset mid-frame: all outputs return to their reset values asynchronously. Counting restarts cleanly at (0,0) on the first edge after release, with frame_start=1 and frame_count=0.
- No enable input; the block runs free whenever reset_n is high.

Test Plan:
- Hold reset_n low 3 clocks, release:
  - During reset: DrawX=799, DrawY=524, blank=0, hs=1, vs=1.
  - First edge after release: DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_count=0.
- Default parameters, one line:
  - blank falls in the cycle DrawX=640.
  - hs goes low 1 clock after DrawX=656 and stays low exactly 96 clocks.
  - line_start is high only at DrawX=0; the line period is 800 clocks.
- Line wrap: DrawX 799→0 while DrawY increments 9→10 on the same edge; no duplicate or missing count.
- Full frame:
  - vs is low for exactly 1600 clocks, starting 1 clock after (DrawX=0, DrawY=490).
  - The frame period is 420000 clocks.
  - frame_count steps 0→1→2 across three frame_start pulses.
- Assert reset_n at DrawX=300, DrawY=200 between clock edges:
  - Outputs go to their reset values before the next edge.
  - After release, counting restarts at (0,0) with frame_count=0.
- SYNC_DELAY=0, HS_POL=1, VS_POL=1:
  - hs is high exactly while DrawX ∈ 656..751.
  - vs is high exactly while DrawY ∈ 490..491.
  - hs and vs are 0 during reset.
